// File: rtl/lsu_controller.sv
// Load/store unit sequencer: accepts one memory instruction from execute, drives the
// data-memory port until it handshakes, and returns aligned/extended load data.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    input  logic        load_req_in,
    input  logic        store_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [3:0]  dmem_wmask_out,
    output logic [31:0] dmem_wdata_out,
    input  logic        dmem_ready_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_out,
    output logic        timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_DONE    = 3'd2,
        S_FAULT   = 3'd3,
        S_TOFAULT = 3'd4
    } state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [31:0] sd_q, sd_d;
    logic [31:0] load_data_q, load_data_d;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = a[1] | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{sd[7:0]}};
            2'b01:   d = {2{sd[15:0]}};
            default: d = sd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic uns,
                                            input logic [1:0] a, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        case (size)
            2'b00: begin
                sh  = rdata >> {a, 3'b000};
                res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh  = rdata >> {a[1], 4'b0000};
                res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                sh  = rdata;
                res = rdata;
            end
        endcase
        return res;
    endfunction

    // State and latched-request registers; reset discards any access in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'h0000;
            addr_q      <= 32'h0000_0000;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            sd_q        <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            sd_q        <= sd_d;
            load_data_q <= load_data_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        size_d         = size_q;
        uns_d          = uns_q;
        we_d           = we_q;
        sd_d           = sd_q;
        load_data_d    = load_data_q;
        dmem_req_out   = 1'b0;
        dmem_we_out    = 1'b0;
        dmem_addr_out  = 32'h0000_0000;
        dmem_wmask_out = 4'b0000;
        dmem_wdata_out = 32'h0000_0000;
        stall_out      = 1'b0;
        load_valid_out = 1'b0;
        misaligned_out = 1'b0;
        timeout_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_in && (load_req_in || store_req_in)) begin
                    // Both direction flags at once is a decoder fault, not a request.
                    if ((load_req_in && store_req_in) ||
                        is_misaligned(load_size_in, addr_in[1:0])) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d   = S_ACCESS;
                        cnt_d     = 16'h0000;
                        addr_d    = addr_in;
                        size_d    = load_size_in;
                        uns_d     = load_unsigned_in;
                        we_d      = store_req_in;
                        sd_d      = store_data_in;
                        stall_out = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                dmem_req_out   = 1'b1;
                dmem_we_out    = we_q;
                dmem_addr_out  = {addr_q[31:2], 2'b00};
                dmem_wmask_out = we_q ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
                dmem_wdata_out = we_q ? lane_data(size_q, sd_q) : 32'h0000_0000;
                stall_out      = 1'b1;
                if (dmem_ready_in) begin
                    state_d = S_DONE;
                    cnt_d   = 16'h0000;
                    if (!we_q) begin
                        load_data_d = extract(size_q, uns_q, addr_q[1:0], dmem_rdata_in);
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TOFAULT;
                    cnt_d   = 16'h0000;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            S_DONE: begin
                load_valid_out = ~we_q;
                cnt_d          = 16'h0000;
                state_d        = S_IDLE;
            end
            S_FAULT: begin
                misaligned_out = 1'b1;
                state_d        = S_IDLE;
            end
            S_TOFAULT: begin
                timeout_out = 1'b1;
                cnt_d       = 16'h0000;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'h0000;
            end
        endcase
    end

    assign load_data_out = load_data_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed vector table, hand-written
// reset/back-to-back sequences, and randomized transactions against a transaction-level model.
module tb_lsu_controller;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        load_req = 1'b0;
    logic        store_req = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] sd = 32'h0;
    logic        ready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        req, we, stall, load_valid, misaligned, timeout;
    logic [31:0] maddr, wdata, load_data;
    logic [3:0]  wmask;

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          exp_hs = 0;
    logic [31:0] exp_last = 32'h0;

    lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .load_req_in(load_req),
        .store_req_in(store_req), .load_size_in(size), .load_unsigned_in(uns),
        .addr_in(addr), .store_data_in(sd), .dmem_req_out(req), .dmem_we_out(we),
        .dmem_addr_out(maddr), .dmem_wmask_out(wmask), .dmem_wdata_out(wdata),
        .dmem_ready_in(ready), .dmem_rdata_in(rdata), .stall_out(stall),
        .load_data_out(load_data), .load_valid_out(load_valid),
        .misaligned_out(misaligned), .timeout_out(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && req && ready) hs_count <= hs_count + 1;
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          wt;
        logic        fault;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] data;
    } vec_t;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectations straight from the lane/extension rules.
    function automatic vec_t model(input vec_t v);
        int a;
        logic [31:0] b;
        a = int'(v.addr[1:0]);
        v.fault = (v.ld && v.st) || (v.size == 2'b11) ||
                  (v.size == 2'b01 && (a % 2) != 0) || (v.size == 2'b10 && a != 0);
        case (v.size)
            2'b00: begin
                v.mask  = 4'(1 << a);
                v.wdata = (v.sd & 32'hFF) * 32'h0101_0101;
                b = (v.rdata >> (8 * a)) & 32'hFF;
                if (!v.uns && b >= 32'd128) b = b - 32'd256;
            end
            2'b01: begin
                v.mask  = (a >= 2) ? 4'b1100 : 4'b0011;
                v.wdata = (v.sd & 32'hFFFF) * 32'h0001_0001;
                b = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
                if (!v.uns && b >= 32'd32768) b = b - 32'd65536;
            end
            default: begin
                v.mask  = 4'b1111;
                v.wdata = v.sd;
                b = v.rdata;
            end
        endcase
        v.data = b;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        valid = 1'b1; load_req = v.ld; store_req = v.st; size = v.size;
        uns = v.uns; addr = v.addr; sd = v.sd;
    endtask

    task automatic drive_junk();
        valid = 1'($urandom); load_req = 1'($urandom); store_req = 1'($urandom);
        size = 2'($urandom); uns = 1'($urandom); addr = $urandom; sd = $urandom;
    endtask

    task automatic clear_inputs();
        valid = 1'b0; load_req = 1'b0; store_req = 1'b0; size = 2'b00;
        uns = 1'b0; addr = 32'h0; sd = 32'h0;
    endtask

    // Entered and left at posedge+1 in IDLE; checks every cycle of one access.
    task automatic run_txn(input vec_t v, input bit hold, input vec_t nxt);
        bit tmo;
        tmo = !v.fault && (v.wt >= int'(TO));
        drive_req(v);
        ready = 1'b0;
        #4;
        chk1("idle_stall", stall, !v.fault);
        chk1("idle_req", req, 1'b0);
        @(posedge clk); #1;
        if (v.fault) begin
            if (hold) drive_req(nxt); else drive_junk();
            #4;
            chk1("fault_pulse", misaligned, 1'b1);
            chk1("fault_req", req, 1'b0);
            chk1("fault_stall", stall, 1'b0);
        end else begin
            for (int k = 0; k < int'(TO); k++) begin
                drive_junk();
                ready = (k == v.wt);
                rdata = ready ? v.rdata : $urandom;
                #4;
                chk1("acc_req", req, 1'b1);
                chk1("acc_stall", stall, 1'b1);
                chk1("acc_we", we, v.st);
                chk32("acc_addr", maddr, {v.addr[31:2], 2'b00});
                if (v.st) begin
                    chk32("acc_mask", {28'h0, wmask}, {28'h0, v.mask});
                    chk32("acc_wdata", wdata, v.wdata);
                end else begin
                    chk32("acc_mask_rd", {28'h0, wmask}, 32'h0);
                end
                @(posedge clk); #1;
                if (k == v.wt) break;
            end
            ready = 1'b0;
            if (hold) drive_req(nxt); else drive_junk();
            #4;
            if (tmo) begin
                chk1("tmo_pulse", timeout, 1'b1);
                chk1("tmo_lv", load_valid, 1'b0);
            end else begin
                exp_hs++;
                chk1("done_lv", load_valid, v.ld);
                if (v.ld) begin
                    exp_last = v.data;
                    chk32("done_data", load_data, v.data);
                end
            end
            chk1("end_req", req, 1'b0);
            chk1("end_stall", stall, 1'b0);
        end
        @(posedge clk); #1;
        if (hold) begin
            drive_req(nxt);
        end else begin
            clear_inputs();
            #4;
            chk1("rest_stall", stall, 1'b0);
            chk1("rest_req", req, 1'b0);
            chk1("rest_pulses", load_valid | misaligned | timeout, 1'b0);
            chk32("rest_data", load_data, exp_last);
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[13];
    vec_t none;
    vec_t v, w;

    initial begin
        // {ld, st, size, uns, addr, sd, rdata, wait, fault, mask, wdata, data}
        tbl[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h1003, 32'hAABBCCDD, 32'h0, 0, 1'b0, 4'b1000, 32'hDDDDDDDD, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 3, 1'b0, 4'b0, 32'h0, 32'hFFFF8001};
        tbl[2]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 3, 1'b0, 4'b0, 32'h0, 32'h00008001};
        tbl[3]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h3003, 32'h1234, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h5001, 32'h0, 32'h1234_F678, 1, 1'b0, 4'b0, 32'h0, 32'hFFFFFFF6};
        tbl[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h6000, 32'h11223344, 32'h0, 2, 1'b0, 4'b1111, 32'h11223344, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h6002, 32'hCAFE5A5A, 32'h0, 0, 1'b0, 4'b1100, 32'h5A5A5A5A, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h7000, 32'h0, 32'h0, 9, 1'b0, 4'b0, 32'h0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h8004, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'b0, 32'h0, 32'hDEADBEEF};
        tbl[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h9000, 32'h0, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'hA003, 32'h0, 32'h80FF_FFFF, 0, 1'b0, 4'b0, 32'h0, 32'h00000080};
        none = tbl[0];

        #2;
        chk1("rst_req", req, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_pulses", load_valid | misaligned | timeout | we, 1'b0);
        chk32("rst_data", load_data, 32'h0);
        chk32("rst_wdata", wdata, 32'h0);
        chk32("rst_addr", maddr, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_txn(tbl[i], 1'b0, none);

        // Reset asserted in the middle of ACCESS drops the request at once.
        v = model('{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0, 4'b0, 32'h0, 32'h0});
        drive_req(v);
        ready = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        #2;
        chk1("mid_req_before", req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_req_after", req, 1'b0);
        chk1("mid_stall_after", stall, 1'b0);
        chk32("mid_data", load_data, 32'h0);
        exp_last = 32'h0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        v = model('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 0, 1'b0, 4'b0, 32'h0, 32'h0});
        run_txn(v, 1'b0, none);

        // Store presented during DONE must wait until IDLE.
        v = model('{1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h13579BDF, 0, 1'b0, 4'b0, 32'h0, 32'h0});
        w = model('{1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h000000A5, 32'h0, 0, 1'b0, 4'b0, 32'h0, 32'h0});
        run_txn(v, 1'b1, w);
        run_txn(w, 1'b0, none);

        for (int i = 0; i < 40; i++) begin
            v.ld    = 1'($urandom);
            v.st    = ($urandom_range(0, 15) == 0) ? 1'b1 : !v.ld;
            v.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v.uns   = 1'($urandom);
            v.addr  = $urandom;
            v.sd    = $urandom;
            v.rdata = $urandom;
            v.wt    = int'($urandom_range(0, 5));
            run_txn(model(v), 1'b0, none);
        end

        chk32("handshakes", 32'(hs_count), 32'(exp_hs));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
